// File: rtl/maze_generator.sv
// Binary-tree perfect-maze generator, one cell carved per clock from a 16-bit LFSR.
// Define MAZE_GEN_OPENINGS_EN to also open the entry/exit border segments on completion.
module maze_generator #(
    parameter int          COLS         = 10,
    parameter int          ROWS         = 15,
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [15:0]                seed,
    output logic [(ROWS+1)*COLS-1:0]   h_walls,
    output logic [ROWS*(COLS+1)-1:0]   v_walls,
    output logic                       busy,
    output logic                       done
);

    localparam int HW  = (ROWS + 1) * COLS;
    localparam int VW  = ROWS * (COLS + 1);
    localparam int HIW = $clog2(HW);
    localparam int VIW = $clog2(VW);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_CARVE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic           top_row;
    logic           last_col;
    logic           last_row;
    logic           go_north;
    logic           go_east;
    logic           lfsr_fb;
    logic [HIW-1:0] north_idx;
    logic [VIW-1:0] east_idx;

    assign top_row   = (row_q == '0);
    assign last_col  = (col_q == CW'(COLS - 1));
    assign last_row  = (row_q == RW'(ROWS - 1));
    assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign north_idx = HIW'(32'(row_q) * COLS + 32'(col_q));
    assign east_idx  = VIW'(32'(row_q) * (COLS + 1) + 32'(col_q) + 1);

    // Top row can only go east, last column can only go north.
    always_comb begin
        go_north = 1'b0;
        go_east  = 1'b0;
        if (top_row) begin
            go_east = !last_col;
        end else if (last_col) begin
            go_north = 1'b1;
        end else begin
            go_north = lfsr_q[0];
            go_east  = !lfsr_q[0];
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        row_d   = row_q;
        col_d   = col_q;
        h_d     = h_q;
        v_d     = v_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lfsr_d  = (seed == 16'h0000) ? SEED_DEFAULT : seed;
                    busy_d  = 1'b1;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                h_d     = '1;
                v_d     = '1;
                row_d   = '0;
                col_d   = '0;
                state_d = S_CARVE;
            end
            S_CARVE: begin
                lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                if (go_north) begin
                    h_d[north_idx] = 1'b0;
                end
                if (go_east) begin
                    v_d[east_idx] = 1'b0;
                end
                if (last_col) begin
                    col_d = '0;
                    if (last_row) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
`ifdef MAZE_GEN_OPENINGS_EN
                        h_d[0]      = 1'b0;
                        h_d[HW - 1] = 1'b0;
`endif
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_DEFAULT;
            row_q   <= '0;
            col_q   <= '0;
            h_q     <= '1;
            v_q     <= '1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            row_q   <= row_d;
            col_q   <= col_d;
            h_q     <= h_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign h_walls = h_q;
    assign v_walls = v_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_maze_generator.sv
// Self-checking bench for maze_generator: reference maze model, flood fill, timing.
// Honours MAZE_GEN_OPENINGS_EN when defined for the build.
module tb_maze_generator;

    localparam int C   = 10;
    localparam int R   = 15;
    localparam int HW  = (R + 1) * C;
    localparam int VW  = R * (C + 1);
    localparam int N   = R * C;
    localparam int LAT = N + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   seed = 16'h0000;
    logic [HW-1:0] h_walls;
    logic [VW-1:0] v_walls;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    maze_generator #(
        .COLS(C),
        .ROWS(R),
        .SEED_DEFAULT(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .seed(seed),
        .h_walls(h_walls),
        .v_walls(v_walls),
        .busy(busy),
        .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: walk cells row-major, one LFSR step per cell.
    function automatic void model(input logic [15:0] s,
                                  output logic [HW-1:0] h,
                                  output logic [VW-1:0] v);
        int l, r, c, fb;
        l = (s == 16'h0000) ? 32'hACE1 : int'(s);
        h = '1;
        v = '1;
        for (int k = 0; k < N; k++) begin
            r = k / C;
            c = k % C;
            if (r == 0) begin
                if (c != C - 1) v[r*(C+1)+c+1] = 1'b0;
            end else if (c == C - 1) begin
                h[r*C+c] = 1'b0;
            end else if ((l & 1) == 1) begin
                h[r*C+c] = 1'b0;
            end else begin
                v[r*(C+1)+c+1] = 1'b0;
            end
            fb = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
            l = ((l >> 1) | (fb << 15)) & 32'hFFFF;
        end
`ifdef MAZE_GEN_OPENINGS_EN
        h[0] = 1'b0;
        h[N+C-1] = 1'b0;
`endif
    endfunction

    function automatic int reach(input logic [HW-1:0] h, input logic [VW-1:0] v);
        bit seen[N];
        int q[$];
        int cnt, k, r, c;
        cnt = 0;
        for (int i = 0; i < N; i++) seen[i] = 1'b0;
        q.push_back(0);
        seen[0] = 1'b1;
        while (q.size() > 0) begin
            k = q.pop_front();
            cnt++;
            r = k / C;
            c = k % C;
            if (r > 0 && !h[r*C+c] && !seen[k-C]) begin
                seen[k-C] = 1'b1; q.push_back(k - C);
            end
            if (r < R - 1 && !h[(r+1)*C+c] && !seen[k+C]) begin
                seen[k+C] = 1'b1; q.push_back(k + C);
            end
            if (c > 0 && !v[r*(C+1)+c] && !seen[k-1]) begin
                seen[k-1] = 1'b1; q.push_back(k - 1);
            end
            if (c < C - 1 && !v[r*(C+1)+c+1] && !seen[k+1]) begin
                seen[k+1] = 1'b1; q.push_back(k + 1);
            end
        end
        return cnt;
    endfunction

    function automatic int interior_open(input logic [HW-1:0] h, input logic [VW-1:0] v);
        int n;
        n = 0;
        for (int r = 1; r < R; r++)
            for (int c = 0; c < C; c++)
                if (!h[r*C+c]) n++;
        for (int r = 0; r < R; r++)
            for (int c = 1; c < C; c++)
                if (!v[r*(C+1)+c]) n++;
        return n;
    endfunction

    function automatic bit border_closed(input logic [HW-1:0] h, input logic [VW-1:0] v);
        bit ok;
        ok = 1'b1;
        for (int c = 0; c < C; c++) begin
            if (!h[c] && c != 0) ok = 1'b0;
            if (!h[R*C+c] && c != C - 1) ok = 1'b0;
        end
`ifndef MAZE_GEN_OPENINGS_EN
        if (!h[0] || !h[N+C-1]) ok = 1'b0;
`endif
        for (int r = 0; r < R; r++) begin
            if (!v[r*(C+1)]) ok = 1'b0;
            if (!v[r*(C+1)+C]) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic run_gen(input logic [15:0] s, input int p1, input int p2,
                           input logic [15:0] ps,
                           output logic [HW-1:0] h, output logic [VW-1:0] v,
                           output int lat, output bit busy_ok, output bit done_once);
        int cyc;
        seed = s;
        start = 1'b1;
        tick;
        start = 1'b0;
        seed = 16'($urandom);
        cyc = 1;
        busy_ok = busy;
        while (!done && cyc < 4 * LAT) begin
            start = (cyc == p1 || cyc == p2);
            if (start) seed = ps;
            tick;
            cyc++;
            if (!done && !busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        lat = cyc;
        if (done && busy) busy_ok = 1'b0;
        h = h_walls;
        v = v_walls;
        tick;
        done_once = !done;
    endtask

    task automatic test_reset;
        int seen_done;
        seen_done = 0;
        rst = 1'b1;
        start = 1'b0;
        seed = 16'h0000;
        repeat (3) tick;
        rst = 1'b0;
        total++;
        if (h_walls !== '1) begin bad++; $display("FAIL reset_h: got %h want all ones", h_walls); end
        total++;
        if (v_walls !== '1) begin bad++; $display("FAIL reset_v: got %h want all ones", v_walls); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        repeat (200) begin
            tick;
            if (done !== 1'b0) seen_done++;
        end
        total++;
        if (seen_done != 0) begin bad++; $display("FAIL idle_done: got %0d pulses want 0", seen_done); end
    endtask

    task automatic test_basic;
        logic [HW-1:0] h, eh;
        logic [VW-1:0] v, ev;
        int lat, n;
        bit bok, d1, top_ok;
        run_gen(16'h0001, -1, -1, 16'h0000, h, v, lat, bok, d1);
        model(16'h0001, eh, ev);
        total++;
        if (lat != LAT) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT); end
        total++;
        if (!bok) begin bad++; $display("FAIL basic_busy: got window broken want high T+1..T+%0d", LAT - 1); end
        total++;
        if (!d1) begin bad++; $display("FAIL basic_done_width: got %b want 0 after pulse", done); end
        total++;
        if (h !== eh) begin bad++; $display("FAIL basic_h: got %h want %h", h, eh); end
        total++;
        if (v !== ev) begin bad++; $display("FAIL basic_v: got %h want %h", v, ev); end
        n = reach(h, v);
        total++;
        if (n != N) begin bad++; $display("FAIL basic_reach: got %0d want %0d", n, N); end
        n = interior_open(h, v);
        total++;
        if (n != N - 1) begin bad++; $display("FAIL basic_cleared: got %0d want %0d", n, N - 1); end
        top_ok = 1'b1;
        for (int c = 1; c < C; c++) if (v[c] !== 1'b0) top_ok = 1'b0;
        total++;
        if (!top_ok) begin bad++; $display("FAIL basic_toprow: got %h want interior zero", v[C:0]); end
        total++;
        if (!border_closed(h, v)) begin bad++; $display("FAIL basic_border: got h=%h v=%h", h, v); end
        repeat (20) tick;
        total++;
        if (h_walls !== h || v_walls !== v) begin
            bad++; $display("FAIL basic_hold: got h=%h want %h", h_walls, h);
        end
    endtask

    task automatic test_determinism;
        logic [HW-1:0] h1, h2, eh;
        logic [VW-1:0] v1, v2, ev;
        int lat;
        bit bok, d1;
        run_gen(16'h1234, -1, -1, 16'h0000, h1, v1, lat, bok, d1);
        run_gen(16'h1234, -1, -1, 16'h0000, h2, v2, lat, bok, d1);
        total++;
        if (h1 !== h2 || v1 !== v2) begin bad++; $display("FAIL det_repeat: got h=%h want %h", h2, h1); end
        model(16'h1234, eh, ev);
        total++;
        if (h1 !== eh || v1 !== ev) begin bad++; $display("FAIL det_model: got h=%h want %h", h1, eh); end
        run_gen(16'h4321, -1, -1, 16'h0000, h2, v2, lat, bok, d1);
        total++;
        if (h1 === h2 && v1 === v2) begin bad++; $display("FAIL det_differ: got h=%h want not %h", h2, h1); end
        run_gen(16'h0000, -1, -1, 16'h0000, h1, v1, lat, bok, d1);
        run_gen(16'hACE1, -1, -1, 16'h0000, h2, v2, lat, bok, d1);
        total++;
        if (h1 !== h2 || v1 !== v2) begin bad++; $display("FAIL det_zero_seed: got h=%h want %h", h1, h2); end
        model(16'hACE1, eh, ev);
        total++;
        if (h1 !== eh || v1 !== ev) begin bad++; $display("FAIL det_zero_model: got v=%h want %h", v1, ev); end
    endtask

    task automatic test_ignored_start;
        logic [HW-1:0] h, eh;
        logic [VW-1:0] v, ev;
        int lat;
        bit bok, d1;
        run_gen(16'h5A5A, 10, 100, 16'h1111, h, v, lat, bok, d1);
        model(16'h5A5A, eh, ev);
        total++;
        if (lat != LAT) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", lat, LAT); end
        total++;
        if (h !== eh || v !== ev) begin bad++; $display("FAIL ignore_walls: got h=%h want %h", h, eh); end
    endtask

    task automatic test_reset_mid;
        logic [HW-1:0] h, eh;
        logic [VW-1:0] v, ev;
        logic [15:0] s;
        int lat, seen_done;
        bit bok, d1;
        seed = 16'h1234;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (59) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        total++;
        if (h_walls !== '1 || v_walls !== '1) begin
            bad++; $display("FAIL midrst_walls: got h=%h want all ones", h_walls);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midrst_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        seen_done = 0;
        repeat (LAT + 10) begin
            tick;
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        total++;
        if (seen_done != 0) begin bad++; $display("FAIL midrst_abandon: got %0d active cycles want 0", seen_done); end
        s = 16'($urandom_range(1, 16'hFFFF));
        run_gen(s, -1, -1, 16'h0000, h, v, lat, bok, d1);
        model(s, eh, ev);
        total++;
        if (lat != LAT || !bok) begin bad++; $display("FAIL midrst_rerun: got lat=%0d busy_ok=%b want %0d 1", lat, bok, LAT); end
        total++;
        if (h !== eh || v !== ev) begin bad++; $display("FAIL midrst_walls2: got h=%h want %h", h, eh); end
    endtask

    task automatic test_random;
        logic [HW-1:0] h, eh;
        logic [VW-1:0] v, ev;
        logic [15:0] s;
        int lat, n;
        bit bok, d1;
        for (int i = 0; i < 4; i++) begin
            s = 16'($urandom);
            run_gen(s, -1, -1, 16'h0000, h, v, lat, bok, d1);
            model(s, eh, ev);
            total++;
            if (h !== eh || v !== ev) begin bad++; $display("FAIL rand_walls seed=%h: got h=%h want %h", s, h, eh); end
            n = reach(h, v);
            total++;
            if (n != N) begin bad++; $display("FAIL rand_reach seed=%h: got %0d want %0d", s, n, N); end
        end
    endtask

    task automatic test_back_to_back;
        logic [HW-1:0] eh;
        logic [VW-1:0] ev;
        int cyc;
        bit busy2;
        seed = 16'hBEEF;
        start = 1'b1;
        tick;
        cyc = 1;
        while (!done && cyc < 4 * LAT) begin tick; cyc++; end
        total++;
        if (cyc != LAT) begin bad++; $display("FAIL b2b_first: got %0d want %0d", cyc, LAT); end
        cyc = 0;
        busy2 = 1'b0;
        do begin
            tick;
            cyc++;
            if (cyc == 2) busy2 = busy;
        end while (!done && cyc < 4 * LAT);
        start = 1'b0;
        total++;
        if (cyc != LAT + 1) begin bad++; $display("FAIL b2b_second: got %0d want %0d", cyc, LAT + 1); end
        total++;
        if (busy2 !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", busy2); end
        model(16'hBEEF, eh, ev);
        total++;
        if (h_walls !== eh || v_walls !== ev) begin bad++; $display("FAIL b2b_walls: got h=%h want %h", h_walls, eh); end
        tick;
    endtask

    task automatic test_openings;
        logic [HW-1:0] h, eh;
        logic [VW-1:0] v, ev;
        logic expect_bit;
        int lat;
        bit bok, d1;
`ifdef MAZE_GEN_OPENINGS_EN
        expect_bit = 1'b0;
`else
        expect_bit = 1'b1;
`endif
        run_gen(16'h7777, -1, -1, 16'h0000, h, v, lat, bok, d1);
        total++;
        if (h[0] !== expect_bit) begin bad++; $display("FAIL open_entry: got %b want %b", h[0], expect_bit); end
        total++;
        if (h[N+C-1] !== expect_bit) begin bad++; $display("FAIL open_exit: got %b want %b", h[N+C-1], expect_bit); end
        model(16'h7777, eh, ev);
        total++;
        if (h !== eh || v !== ev) begin bad++; $display("FAIL open_walls: got h=%h want %h", h, eh); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_determinism();
        test_ignored_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_openings();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maze_generator.md
Name: maze_generator

Overview:
Produces the horizontal and vertical wall bitmaps consumed by scene_exhibitor, replacing the hard-coded test walls in the top level. It builds a perfect maze (exactly one path between any two cells) with the binary-tree algorithm, carving one cell per clock. Randomness comes from a 16-bit LFSR loaded with a seed at start. It sits upstream of scene_exhibitor; the top level enables the scene only after done.

Parameters:
COLS, 10, maze width in cells
ROWS, 15, maze height in cells
SEED_DEFAULT, 16'hACE1, LFSR load value used when seed input is zero

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request to generate; honoured only in IDLE
seed  input  16  LFSR seed, sampled on the accepted start cycle
h_walls  output  (ROWS+1)*COLS  horizontal segments; bit r*COLS+c = segment above cell (r,c); r=ROWS is bottom border; 1 = wall
v_walls  output  ROWS*(COLS+1)  vertical segments; bit r*(COLS+1)+c = segment left of cell (r,c); c=COLS is right border; 1 = wall
busy  output  1  high while generation is in progress
done  output  1  one-cycle pulse when the maze is complete and stable

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst; all state updates on posedge clk.
- Reset values: h_walls all 1, v_walls all 1, busy 0, done 0, state IDLE, LFSR = SEED_DEFAULT, cell counters 0.
- States: IDLE -> INIT -> CARVE -> DONE -> IDLE.
- IDLE: start=1 at cycle T -> INIT at T+1. The LFSR loads seed, or SEED_DEFAULT if seed==0. busy goes high at T+1.
- INIT: sets every h_walls and v_walls bit to 1. Clears row=0, col=0. Next state is CARVE.
- CARVE: processes one cell (row,col) per cycle in row-major order, row 0 = top. The LFSR advances every CARVE cycle. Decision bit is lfsr[0], taken before the shift.
  - row==0 and col<COLS-1: clear the east wall, v bit row*(COLS+1)+col+1.
  - row>0 and col==COLS-1: clear the north wall, h bit row*COLS+col.
  - row==0 and col==COLS-1: no carve.
  - Otherwise: lfsr[0]=1 clears north, 0 clears east.
  - After cell (ROWS-1, COLS-1), go to DONE.
- LFSR: Fibonacci, shift right, taps x^16+x^14+x^13+x^11+1. New MSB = l[0]^l[2]^l[3]^l[5]. It never reaches 0 because a 0 seed is substituted.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE. Walls hold until the next accepted start.
- Latency: with start at T, done=1 at T+2+ROWS*COLS (T+152 at defaults). busy is high T+1 .. T+151.
- Exactly ROWS*COLS-1 interior segments are cleared. Border segments (top row, bottom row, column 0 left, column COLS right) are never cleared.
- start while busy or in DONE: ignored, no restart, seed not resampled.
- start held high continuously: a new generation begins on the first IDLE cycle after DONE.
- Wall outputs change during CARVE; consumers sample only when busy=0.
- rst mid-generation: next cycle shows reset values, and the generation is abandoned.
- Wall bits are registers, not combinational; no output depends combinationally on inputs.

Optional Feature:
MAZE_GEN_OPENINGS_EN
- Defined: during the DONE cycle, h bit 0 (entry, top of cell (0,0)) and h bit ROWS*COLS+COLS-1 (exit, bottom of cell (ROWS-1,COLS-1)) are also cleared. Visible from the done pulse onward.
- Not defined: all border segments remain 1.

Test Plan:
- Reset: assert rst 3 cycles -> h_walls all 1, v_walls all 1, busy=0, done=0; no done while idle for 200 cycles.
- start=1 for one cycle with seed=16'h0001 -> busy rises next cycle; done pulses exactly 152 cycles after start. Bench flood-fill from cell (0,0) reaches all 150 cells. Cleared interior segments = 149. Top row interior v bits all 0.
- Determinism: run seed=16'h1234 twice; also run seed=0 vs seed=16'hACE1 -> identical bitmaps within each pair. seed=16'h1234 vs 16'h4321 -> bitmaps differ.
- start pulsed at cycles +10 and +100 during generation -> ignored; done still at T+152; result equals an undisturbed run with the same seed.
- rst asserted at cycle T+60 -> next cycle all walls 1, busy=0. A subsequent start produces a full 152-cycle run.
- With MAZE_GEN_OPENINGS_EN: after done, h bit 0 = 0 and h bit 159 = 0. Without the macro, both = 1.
